// File: rtl/simon_pkg.sv
// Shared encodings for the SIMON serial loader.
// Contents: host command / cipher mode codes, loader state enum, host beat
// payload struct and a helper mapping a load/encrypt state to its mode code.
package simon_pkg;

  localparam int unsigned BYTE_BITS = 8;

  // Host command codes; the same values are driven on data_rdy as mode codes.
  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_PT  = 2'b01;
  localparam logic [1:0] CMD_KEY = 2'b10;
  localparam logic [1:0] CMD_ENC = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_PT,
    ST_LOAD_KEY,
    ST_ENCRYPT
  } state_t;

  // One host byte together with its command.
  typedef struct packed {
    logic [1:0]           cmd;
    logic [BYTE_BITS-1:0] data;
  } host_beat_t;

  // Mode code presented to the cipher while a state is actively driving.
  function automatic logic [1:0] rdy_code(input state_t s);
    logic [1:0] code;
    code = CMD_NOP;
    case (s)
      ST_LOAD_PT:  code = CMD_PT;
      ST_LOAD_KEY: code = CMD_KEY;
      ST_ENCRYPT:  code = CMD_ENC;
      default:     code = CMD_NOP;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/simon_serial_loader_if.sv
// Host byte channel plus cipher serial channel of the SIMON loader.
// Signals:
//   in_data/in_cmd/in_valid : host byte, command and valid (host -> loader)
//   in_ready                : loader accepts the byte (loader -> host)
//   cipher_valid            : cipher completion flag (cipher -> loader)
//   data_out/data_rdy       : serial bit and mode code (loader -> cipher)
// master = host/cipher side, slave = loader side.
interface simon_serial_loader_if;

  logic [7:0] in_data;
  logic [1:0] in_cmd;
  logic       in_valid;
  logic       in_ready;
  logic       cipher_valid;
  logic       data_out;
  logic [1:0] data_rdy;

  modport master (
    output in_data,
    output in_cmd,
    output in_valid,
    output cipher_valid,
    input  in_ready,
    input  data_out,
    input  data_rdy
  );

  modport slave (
    input  in_data,
    input  in_cmd,
    input  in_valid,
    input  cipher_valid,
    output in_ready,
    output data_out,
    output data_rdy
  );

endinterface

// File: rtl/simon_bit_shifter.sv
// Byte-to-bit shifter: holds the current host byte and shifts it right one
// bit per emitted bit (LSB first).
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   i_load        : capture i_data (wins over i_shift)
//   i_shift       : shift right by one, zero fill
//   i_data        : byte to capture
//   o_next_bit_c  : LSB the register will hold after this edge (combinational)
module simon_bit_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_shift,
  input  logic [7:0] i_data,
  output logic       o_next_bit_c
);

  logic [7:0] r_sr;
  logic [7:0] w_sr_n;

  // Next shift-register value.
  always_comb begin
    w_sr_n = r_sr;
    if (i_load) begin
      w_sr_n = i_data;
    end else if (i_shift) begin
      w_sr_n = {1'b0, r_sr[7:1]};
    end
  end

  // Exposed so the parent can register the outgoing bit in the same edge.
  assign o_next_bit_c = w_sr_n[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr <= '0;
    end else begin
      r_sr <= w_sr_n;
    end
  end

endmodule

// File: rtl/simon_serial_loader.sv
// Serialises host bytes into the bit-serial SIMON cipher input.
// Bytes tagged plaintext/key are streamed LSB first, one bit per cycle, with
// data_rdy giving the mode; the encrypt command holds data_rdy=11 until the
// cipher raises cipher_valid. All outputs are registered.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : host byte channel and cipher serial channel (slave side)
//   busy       : high whenever the loader is not idle
module simon_serial_loader
  import simon_pkg::*;
#(
  parameter int unsigned BLOCK_BITS = 64,
  parameter int unsigned KEY_BITS   = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  simon_serial_loader_if.slave bus,
  output logic                 busy
);

  localparam int unsigned MAX_BITS = (BLOCK_BITS > KEY_BITS) ? BLOCK_BITS : KEY_BITS;
  // One extra code point so the count of driven bits can reach MAX_BITS.
  localparam int unsigned CNT_W    = $clog2(MAX_BITS + 1);

  state_t           r_state;
  logic             r_have;      // a byte is held and being emitted
  logic [CNT_W-1:0] r_cnt;       // bits already driven in this load
  logic             r_in_ready;
  logic             r_data_out;
  logic [1:0]       r_data_rdy;
  logic             r_busy;

  state_t           w_state_n;
  logic             w_have_n;
  logic [CNT_W-1:0] w_cnt_n;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_total;
  logic [CNT_W-1:0] w_total_n;
  logic             w_load;
  logic             w_shift;
  logic             w_xfer;
  logic             w_next_bit_c;
  logic             w_in_ready_n;
  logic             w_data_out_n;
  logic [1:0]       w_data_rdy_n;
  logic             w_busy_n;
  host_beat_t       w_beat;

  assign w_beat    = '{cmd: bus.in_cmd, data: bus.in_data};
  assign w_xfer    = bus.in_valid & r_in_ready;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_total   = (r_state   == ST_LOAD_KEY) ? CNT_W'(KEY_BITS) : CNT_W'(BLOCK_BITS);
  assign w_total_n = (w_state_n == ST_LOAD_KEY) ? CNT_W'(KEY_BITS) : CNT_W'(BLOCK_BITS);

  simon_bit_shifter u_shifter (
    .clk          (clk),
    .rst          (reset),
    .i_load       (w_load),
    .i_shift      (w_shift),
    .i_data       (w_beat.data),
    .o_next_bit_c (w_next_bit_c)
  );

  // Next state, byte-held flag, bit counter and shifter controls.
  always_comb begin : next_state
    w_state_n = r_state;
    w_have_n  = r_have;
    w_cnt_n   = r_cnt;
    w_load    = 1'b0;
    w_shift   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          case (w_beat.cmd)
            CMD_PT: begin
              w_state_n = ST_LOAD_PT;
              w_have_n  = 1'b1;
              w_cnt_n   = '0;
              w_load    = 1'b1;
            end
            CMD_KEY: begin
              w_state_n = ST_LOAD_KEY;
              w_have_n  = 1'b1;
              w_cnt_n   = '0;
              w_load    = 1'b1;
            end
            CMD_ENC: w_state_n = ST_ENCRYPT;
            default: w_state_n = ST_IDLE;
          endcase
        end
      end
      ST_LOAD_PT, ST_LOAD_KEY: begin
        if (r_have) begin
          w_shift = 1'b1;
          w_cnt_n = w_cnt_inc;
          if (w_cnt_inc == w_total) begin
            w_state_n = ST_IDLE;
            w_have_n  = 1'b0;
            w_cnt_n   = '0;
          end else if (w_cnt_inc[2:0] == 3'd0) begin
            // Byte boundary: chain the next byte or stall with the count held.
            w_load   = w_xfer;
            w_have_n = w_xfer;
          end
        end else if (w_xfer) begin
          w_load   = 1'b1;
          w_have_n = 1'b1;
        end
      end
      ST_ENCRYPT: begin
        if (bus.cipher_valid) begin
          w_state_n = ST_IDLE;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // Outputs for the coming cycle, decoded from the next state.
  always_comb begin : out_decode
    w_in_ready_n = 1'b0;
    w_data_out_n = 1'b0;
    w_data_rdy_n = CMD_NOP;
    w_busy_n     = (w_state_n != ST_IDLE);
    case (w_state_n)
      ST_IDLE: w_in_ready_n = 1'b1;
      ST_LOAD_PT, ST_LOAD_KEY: begin
        if (w_have_n) begin
          w_data_rdy_n = rdy_code(w_state_n);
          w_data_out_n = w_next_bit_c;
          // Open the input only on bit 7 of a byte that is not the last.
          w_in_ready_n = (w_cnt_n[2:0] == 3'd7) && ((w_cnt_n + CNT_W'(1)) < w_total_n);
        end else begin
          w_in_ready_n = 1'b1;
        end
      end
      ST_ENCRYPT: w_data_rdy_n = CMD_ENC;
      default: w_data_rdy_n = CMD_NOP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_have     <= 1'b0;
      r_cnt      <= '0;
      r_in_ready <= 1'b0;
      r_data_out <= 1'b0;
      r_data_rdy <= CMD_NOP;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_have     <= w_have_n;
      r_cnt      <= w_cnt_n;
      r_in_ready <= w_in_ready_n;
      r_data_out <= w_data_out_n;
      r_data_rdy <= w_data_rdy_n;
      r_busy     <= w_busy_n;
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.data_out = r_data_out;
  assign bus.data_rdy = r_data_rdy;
  assign busy         = r_busy;

endmodule

// File: tb/tb_simon_serial_loader.sv
// Testbench for simon_serial_loader: a queue-based model of the loader is
// compared against the DUT every cycle, plus directed literal checks.
module tb_simon_serial_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;

  simon_serial_loader_if bus ();

  simon_serial_loader #(.BLOCK_BITS(64), .KEY_BITS(128)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: phase, pending bits of accepted bytes, bits sent, bits required.
  typedef enum {M_IDLE, M_LOAD, M_ENC} mphase_t;
  mphase_t    m_phase;
  logic [1:0] m_mode;
  logic       m_fresh;
  logic       m_bits[$];
  int         m_sent;
  int         m_total;

  // Monitor logs.
  logic pt_log[$];
  logic key_log[$];
  int   cyc = 0;
  int   pt_first, pt_last, enc_cnt, enc_ready_cnt, stall_cnt;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_expect(output logic [1:0] e_rdy, output logic e_ready,
                                   output logic e_dout, output logic e_busy);
    e_rdy = 2'b00; e_ready = 1'b0; e_dout = 1'b0; e_busy = 1'b0;
    if (reset || m_fresh) return;
    case (m_phase)
      M_IDLE: e_ready = 1'b1;
      M_LOAD: begin
        e_busy = 1'b1;
        if (m_bits.size() > 0) begin
          e_rdy   = m_mode;
          e_dout  = m_bits[0];
          e_ready = (m_bits.size() == 1) && (m_sent + 1 < m_total);
        end else begin
          e_ready = 1'b1;
        end
      end
      default: begin
        e_busy = 1'b1;
        e_rdy  = 2'b11;
      end
    endcase
  endfunction

  task automatic m_reset();
    m_phase = M_IDLE;
    m_mode  = 2'b00;
    m_fresh = 1'b1;
    m_bits.delete();
    m_sent  = 0;
    m_total = 0;
  endtask

  task automatic m_push_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) m_bits.push_back(d[i]);
  endtask

  task automatic m_step();
    logic [1:0] r;
    logic rd, d, b, xfer;
    m_expect(r, rd, d, b);
    xfer = bus.in_valid && rd;
    m_fresh = 1'b0;
    case (m_phase)
      M_IDLE: begin
        if (xfer && (bus.in_cmd == 2'b01 || bus.in_cmd == 2'b10)) begin
          m_phase = M_LOAD;
          m_mode  = bus.in_cmd;
          m_bits.delete();
          m_push_byte(bus.in_data);
          m_sent  = 0;
          m_total = (bus.in_cmd == 2'b01) ? 64 : 128;
        end else if (xfer && bus.in_cmd == 2'b11) begin
          m_phase = M_ENC;
        end
      end
      M_LOAD: begin
        if (m_bits.size() > 0) begin
          void'(m_bits.pop_front());
          m_sent++;
          if (m_sent == m_total) begin
            m_phase = M_IDLE;
            m_bits.delete();
          end
        end
        if (xfer) m_push_byte(bus.in_data);
      end
      default: if (bus.cipher_valid) m_phase = M_IDLE;
    endcase
  endtask

  task automatic clear_logs();
    pt_log.delete();
    key_log.delete();
    pt_first = -1; pt_last = -1;
    enc_cnt = 0; enc_ready_cnt = 0; stall_cnt = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Hold a byte valid until the loader takes it.
  task automatic send_byte(input logic [1:0] c, input logic [7:0] d);
    int n;
    logic done;
    n = 0; done = 1'b0;
    bus.in_cmd = c; bus.in_data = d; bus.in_valid = 1'b1;
    while (!done && n < 300) begin
      @(negedge clk);
      done = (bus.in_ready === 1'b1);
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    chk("send_accepted", 128'(done), 128'(1));
  endtask

  task automatic wait_idle();
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      seen = (busy === 1'b0);
    end
    @(posedge clk); #1;
    chk("idle_reached", 128'(seen), 128'(1));
  endtask

  task automatic wait_ready();
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = (bus.in_ready === 1'b1);
    end
    @(posedge clk); #1;
    chk("ready_seen", 128'(seen), 128'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [127:0] v;
    logic [7:0]   fb;
    bus.in_data = '0; bus.in_cmd = '0; bus.in_valid = 1'b0; bus.cipher_valid = 1'b0;
    m_reset();
    clear_logs();

    fork
      forever begin
        @(posedge clk or posedge reset);
        if (reset) m_reset();
        else m_step();
      end
      forever begin
        logic [1:0] er;
        logic erd, ed, eb;
        @(negedge clk);
        m_expect(er, erd, ed, eb);
        chk("data_rdy", 128'(bus.data_rdy), 128'(er));
        chk("in_ready", 128'(bus.in_ready), 128'(erd));
        chk("data_out", 128'(bus.data_out), 128'(ed));
        chk("busy",     128'(busy),         128'(eb));
        cyc++;
        if (bus.data_rdy == 2'b01) begin
          pt_log.push_back(bus.data_out);
          if (pt_first < 0) pt_first = cyc;
          pt_last = cyc;
        end
        if (bus.data_rdy == 2'b10) key_log.push_back(bus.data_out);
        if (bus.data_rdy == 2'b11) begin
          enc_cnt++;
          if (bus.in_ready) enc_ready_cnt++;
        end
        if (busy && bus.data_rdy == 2'b00) stall_cnt++;
      end
    join_none

    // Reset state and release.
    step(2);
    chk("rst_data_rdy", 128'(bus.data_rdy), 128'(0));
    chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
    chk("rst_busy",     128'(busy),         128'(0));
    reset = 1'b0;
    step(1);
    chk("ready_after_rst", 128'(bus.in_ready), 128'(1));

    // Stray cipher_valid in idle, then a nop byte.
    bus.cipher_valid = 1'b1;
    step(1);
    bus.cipher_valid = 1'b0;
    clear_logs();
    send_byte(2'b00, 8'h5A);
    step(3);
    chk("nop_no_bits", 128'(pt_log.size() + key_log.size()), 128'(0));
    chk("nop_busy", 128'(busy), 128'(0));

    // Plaintext 0x01..0x08; byte 3 carries a key command that must be ignored.
    clear_logs();
    for (int i = 1; i <= 8; i++) send_byte((i == 3) ? 2'b10 : 2'b01, 8'(i));
    wait_idle();
    v = '0;
    for (int i = 0; i < pt_log.size() && i < 128; i++) v[i] = pt_log[i];
    fb = v[7:0];
    chk("pt_count", 128'(pt_log.size()), 128'(64));
    chk("pt_gapless", 128'(pt_last - pt_first + 1), 128'(64));
    chk("pt_first_byte", 128'(fb), 128'(8'h01));
    chk("pt_bits", v, 128'(64'h0807060504030201));
    chk("pt_no_key", 128'(key_log.size()), 128'(0));
    chk("pt_stalls", 128'(stall_cnt), 128'(0));

    // Key of 16 x 0xA5 with in_valid low for three cycles after byte 5.
    clear_logs();
    for (int i = 0; i < 16; i++) begin
      send_byte(2'b10, 8'hA5);
      if (i == 4) begin
        wait_ready();
        step(2);
      end
    end
    wait_idle();
    v = '0;
    for (int i = 0; i < key_log.size() && i < 128; i++) v[i] = key_log[i];
    fb = v[7:0];
    chk("key_count", 128'(key_log.size()), 128'(128));
    chk("key_stalls", 128'(stall_cnt), 128'(3));
    chk("key_first_byte", 128'(fb), 128'(8'hA5));
    chk("key_bits", v, {16{8'hA5}});

    // Encrypt, cipher_valid on the 21st encrypt cycle together with a byte.
    clear_logs();
    send_byte(2'b11, 8'h00);
    step(20);
    bus.cipher_valid = 1'b1;
    bus.in_valid = 1'b1; bus.in_cmd = 2'b01; bus.in_data = 8'hFF;
    step(1);
    bus.cipher_valid = 1'b0;
    bus.in_valid = 1'b0;
    chk("enc_exit_rdy", 128'(bus.data_rdy), 128'(0));
    chk("enc_exit_busy", 128'(busy), 128'(0));
    chk("enc_cycles", 128'(enc_cnt), 128'(21));
    chk("enc_ready_low", 128'(enc_ready_cnt), 128'(0));
    step(3);
    chk("enc_no_load", 128'(pt_log.size()), 128'(0));

    // Reset while key bit 40 is on the wire.
    clear_logs();
    for (int i = 0; i < 6; i++) send_byte(2'b10, 8'hC3);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("midrst_rdy", 128'(bus.data_rdy), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_ready", 128'(bus.in_ready), 128'(0));
    chk("midrst_bits", 128'(key_log.size()), 128'(40));
    step(2);
    reset = 1'b0;
    step(1);
    chk("postrst_ready", 128'(bus.in_ready), 128'(1));
    chk("postrst_busy", 128'(busy), 128'(0));
    step(4);
    chk("postrst_bits", 128'(key_log.size()), 128'(40));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
